// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the pc_gen program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  localparam int          DEF_ADDR_W   = 32;
  localparam int unsigned DEF_STEP     = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0020;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: PC request handshake plus redirect/control inputs.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);

  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_ready;
  logic              stall;
  logic              halt;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              exc_valid;
  logic [ADDR_W-1:0] epc;
  logic              misalign;

  modport master (
    output ce, pc, pc_valid, epc, misalign,
    input  pc_ready, stall, halt, br_valid, br_target, exc_valid
  );

  modport slave (
    input  ce, pc, pc_valid, epc, misalign,
    output pc_ready, stall, halt, br_valid, br_target, exc_valid
  );

endinterface

// File: rtl/pc_gen_next_mux.sv
// Combinational priority select of next pc/epc/misalign for pc_gen.
// PC_GEN_MISALIGN_TRAP_EN turns misaligned branch targets into an exception redirect.
module pc_gen_next_mux
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int unsigned       STEP    = DEF_STEP,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic              i_active,
  input  logic              i_advance,
  input  logic              i_exc_valid,
  input  logic              i_br_valid,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_epc,
  output logic [ADDR_W-1:0] o_pc_nxt,
  output logic [ADDR_W-1:0] o_epc_nxt,
  output logic              o_misalign_nxt,
  output logic              o_redirect
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic w_br_misaligned;
  assign w_br_misaligned = |(i_br_target & LOW_MASK);
`endif

  // Exception beats branch beats sequential advance; IDLE ignores redirects.
  always_comb begin
    o_pc_nxt       = i_pc;
    o_epc_nxt      = i_epc;
    o_misalign_nxt = 1'b0;
    o_redirect     = 1'b0;
    if (i_active) begin
      if (i_exc_valid) begin
        o_pc_nxt   = EXC_VEC;
        o_epc_nxt  = i_pc;
        o_redirect = 1'b1;
      end else if (i_br_valid) begin
        o_redirect = 1'b1;
`ifdef PC_GEN_MISALIGN_TRAP_EN
        if (w_br_misaligned) begin
          o_pc_nxt       = EXC_VEC;
          o_epc_nxt      = i_br_target;
          o_misalign_nxt = 1'b1;
        end else begin
          o_pc_nxt = i_br_target;
        end
`else
        o_pc_nxt = i_br_target & ~LOW_MASK;
`endif
      end else if (i_advance) begin
        o_pc_nxt = i_pc + ADDR_W'(STEP);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: state register, handshake and registered outputs.
// PC_GEN_MISALIGN_TRAP_EN (optional) traps misaligned branch targets to EXC_VEC.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       STEP     = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic              r_ce;
  logic              r_pc_valid;
  logic              r_misalign;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;

  logic              w_pc_valid_nxt;
  logic              w_advance;
  logic              w_redirect;
  logic              w_misalign_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_epc_nxt;

  // Halt outranks acceptance, so a halting cycle never consumes the offered PC.
  assign w_advance = (r_state == RUN) & r_pc_valid & bus.pc_ready & ~bus.stall & ~bus.halt;

  pc_gen_next_mux #(
    .ADDR_W  (ADDR_W),
    .STEP    (STEP),
    .EXC_VEC (EXC_VEC)
  ) u_next_mux (
    .i_active       (r_state != IDLE),
    .i_advance      (w_advance),
    .i_exc_valid    (bus.exc_valid),
    .i_br_valid     (bus.br_valid),
    .i_br_target    (bus.br_target),
    .i_pc           (r_pc),
    .i_epc          (r_epc),
    .o_pc_nxt       (w_pc_nxt),
    .o_epc_nxt      (w_epc_nxt),
    .o_misalign_nxt (w_misalign_nxt),
    .o_redirect     (w_redirect)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_valid_nxt = r_pc_valid;
    case (r_state)
      IDLE: begin
        w_state_nxt    = RUN;
        w_pc_valid_nxt = 1'b1;
      end
      RUN: begin
        if (!w_redirect && bus.halt) begin
          w_state_nxt    = HALTED;
          w_pc_valid_nxt = 1'b0;
        end
      end
      HALTED: begin
        if (w_redirect) begin
          w_state_nxt    = RUN;
          w_pc_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_pc_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state    <= IDLE;
      r_ce       <= CHIP_DISABLE;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_epc      <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ce       <= CHIP_ENABLE;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= w_pc_valid_nxt;
      r_epc      <= w_epc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign bus.ce       = r_ce;
  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pc_valid;
  assign bus.epc      = r_epc;
  assign bus.misalign = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed walk through the fetch scenarios, then random traffic.
module tb_pc_gen;

  localparam int          ADDR_W   = 32;
  localparam int unsigned STEP     = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] EXC_VEC  = 32'h20;
  localparam longint unsigned ADDR_SPAN = 64'h1_0000_0000;
`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int MODE_IDLE   = 0;
  localparam int MODE_RUN    = 1;
  localparam int MODE_HALTED = 2;

  typedef struct {
    int          edgeNo;
    logic        ce;
    logic [31:0] pc;
    logic        pcValid;
    logic [31:0] epc;
    logic        misalign;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edgeCount = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbQ[$];

  int              mMode = MODE_IDLE;
  logic            mCe = 1'b0;
  longint unsigned mPc = 0;
  logic            mValid = 1'b0;
  longint unsigned mEpc = 0;
  logic            mMis = 1'b0;

  pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .STEP     (STEP),
    .RESET_PC (RESET_PC),
    .EXC_VEC  (EXC_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Reference model: what the outputs must be after the next edge, from the PC rules.
  task automatic modelStep(input logic r, rdy, stl, hlt, brv, input logic [31:0] brt, input logic exc);
    longint unsigned tgt;
    tgt = longint'(brt);
    if (r) begin
      mMode = MODE_IDLE; mCe = 0; mPc = RESET_PC; mValid = 0; mEpc = 0; mMis = 0;
    end else if (mMode == MODE_IDLE) begin
      mMode = MODE_RUN; mCe = 1; mValid = 1; mMis = 0;
    end else begin
      mMis = 0;
      if (exc) begin
        mEpc = mPc; mPc = EXC_VEC; mMode = MODE_RUN; mValid = 1;
      end else if (brv) begin
        if (TRAP_EN && (tgt % STEP) != 0) begin
          mEpc = tgt; mPc = EXC_VEC; mMis = 1;
        end else begin
          mPc = tgt - (tgt % STEP);
        end
        mMode = MODE_RUN; mValid = 1;
      end else if (mMode == MODE_RUN) begin
        if (hlt) begin
          mMode = MODE_HALTED; mValid = 0;
        end else if (rdy && !stl) begin
          mPc = (mPc + STEP) % ADDR_SPAN;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, rdy, stl, hlt, brv, input logic [31:0] brt, input logic exc);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.pc_ready  = rdy;
    bus.stall     = stl;
    bus.halt      = hlt;
    bus.br_valid  = brv;
    bus.br_target = brt;
    bus.exc_valid = exc;
    modelStep(r, rdy, stl, hlt, brv, brt, exc);
    e.edgeNo   = edgeCount + 1;
    e.ce       = mCe;
    e.pc       = mPc[31:0];
    e.pcValid  = mValid;
    e.epc      = mEpc[31:0];
    e.misalign = mMis;
    sbQ.push_back(e);
  endtask

  task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL edge=%0d %s got=%h expected=%h", edgeCount, name, got, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("ce", {31'b0, bus.ce}, {31'b0, e.ce});
    compareField("pc_valid", {31'b0, bus.pc_valid}, {31'b0, e.pcValid});
    compareField("pc", bus.pc, e.pc);
    compareField("epc", bus.epc, e.epc);
    compareField("misalign", {31'b0, bus.misalign}, {31'b0, e.misalign});
  endtask

  // Monitor: compare whenever the expectation for the edge just taken is queued.
  always @(negedge clk) begin
    if (sbQ.size() > 0 && sbQ[0].edgeNo <= edgeCount) begin
      exp_t e;
      e = sbQ.pop_front();
      if (e.edgeNo == edgeCount) begin
        checkOutput(e);
      end else begin
        checks++;
        failures++;
        $display("[TB] FAIL stale_entry got_edge=%0d expected_edge=%0d", edgeCount, e.edgeNo);
      end
    end
  end

  initial begin
    logic [31:0] t;
    bus.pc_ready = 0; bus.stall = 0; bus.halt = 0;
    bus.br_valid = 0; bus.br_target = 0; bus.exc_valid = 0;

    repeat (3) applyStimulus(1, 1, 0, 0, 0, 32'h0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);          // 0, 4, 8
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);          // hold 8
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);                     // C
    applyStimulus(0, 1, 1, 0, 1, 32'h100, 0);                   // 100 despite stall
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);                     // 104
    applyStimulus(0, 1, 0, 0, 1, 32'h200, 1);                   // exc wins
    applyStimulus(0, 1, 0, 0, 1, 32'h3C, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);                     // 40
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 0);                     // halt
    repeat (2) applyStimulus(0, 1, 0, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h80, 0);                    // back to RUN
    applyStimulus(0, 0, 0, 0, 1, 32'h102, 0);                   // misaligned target
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);          // wraps to 0
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 0);
    applyStimulus(1, 1, 0, 1, 0, 32'h0, 0);                     // reset from HALTED
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h400, 1);                   // reset during redirect
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 600; i++) begin
      t = $urandom();
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0,
                    t,
                    $urandom_range(0, 15) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
